// File: rtl/rr_arb8_if.sv
// Request/grant bundle between the requesters and the round-robin arbiter.
interface rr_arb8_if;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    // Requester side: drives requests and the owner's done strobe.
    modport master (
        output req,
        output done,
        input  gnt,
        input  gnt_id,
        input  gnt_valid,
        input  timeout
    );

    // Arbiter side.
    modport slave (
        input  req,
        input  done,
        output gnt,
        output gnt_id,
        output gnt_valid,
        output timeout
    );
endinterface

// File: rtl/rr_arb8.sv
// rr_arb8: eight-way round-robin arbiter with registered one-hot grant,
// binary grant index and a hold timeout. A grant is held until the owner
// signals done, drops its request, or has held for MAX_HOLD cycles. At least
// one idle cycle separates consecutive grants.
module rr_arb8 #(
    parameter int MAX_HOLD = 16
) (
    input  logic      clk,
    input  logic      rst,
    rr_arb8_if.slave  bus
);

    // Hold counter value in the last permitted grant cycle.
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_ptr;
    logic [2:0] w_ptr_nxt;
    logic [2:0] r_owner;
    logic [2:0] w_owner_nxt;
    logic [7:0] r_hold_cnt;
    logic [7:0] w_hold_nxt;
    logic [7:0] r_gnt;
    logic [7:0] w_gnt_nxt;
    logic [2:0] r_gnt_id;
    logic       r_gnt_valid;
    logic       r_timeout;
    logic       w_timeout_nxt;

    logic [2:0] w_sel;
    logic       w_found;
    logic       w_rel_done;
    logic       w_rel_drop;
    logic       w_rel_hold;
    logic       w_release;

    // One-hot to binary, same mapping as the 8-to-3 encoder; zero input gives 0.
    function automatic logic [2:0] enc8(input logic [7:0] oh);
        logic [2:0] id;
        id = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) begin
                id = id | 3'(i);
            end else begin
                id = id;
            end
        end
        return id;
    endfunction

    // Rotating priority search: first set request bit starting at r_ptr.
    always_comb begin
        logic [2:0] idx;
        w_sel   = 3'd0;
        w_found = 1'b0;
        idx     = 3'd0;
        for (int k = 0; k < 8; k++) begin
            idx = r_ptr + 3'(k);
            if (!w_found && bus.req[idx]) begin
                w_sel   = idx;
                w_found = 1'b1;
            end else begin
                w_found = w_found;
            end
        end
    end

    // Release conditions, only acted on while a grant is owned.
    assign w_rel_done = bus.done;
    assign w_rel_drop = ~bus.req[r_owner];
    assign w_rel_hold = (r_hold_cnt == HOLD_LAST);
    assign w_release  = (r_state == ST_OWN) & (w_rel_done | w_rel_drop | w_rel_hold);

    // Next-state and next-output logic for the IDLE/OWN machine.
    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_owner_nxt   = r_owner;
        w_hold_nxt    = r_hold_cnt;
        w_gnt_nxt     = r_gnt;
        w_timeout_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ST_OWN;
                    w_owner_nxt = w_sel;
                    w_hold_nxt  = 8'd0;
                    w_gnt_nxt   = 8'd1 << w_sel;
                end else begin
                    w_gnt_nxt   = 8'h00;
                end
            end
            ST_OWN: begin
                if (w_release) begin
                    w_state_nxt   = ST_IDLE;
                    w_ptr_nxt     = r_owner + 3'd1;
                    w_gnt_nxt     = 8'h00;
                    // A forced release is flagged only if nothing else ended the grant.
                    w_timeout_nxt = w_rel_hold & ~w_rel_done & ~w_rel_drop;
                end else begin
                    w_hold_nxt    = r_hold_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = 8'h00;
            end
        endcase
    end

    // State, pointer and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ptr       <= 3'd0;
            r_owner     <= 3'd0;
            r_hold_cnt  <= 8'd0;
            r_gnt       <= 8'h00;
            r_gnt_id    <= 3'd0;
            r_gnt_valid <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_owner     <= w_owner_nxt;
            r_hold_cnt  <= w_hold_nxt;
            r_gnt       <= w_gnt_nxt;
            r_gnt_id    <= enc8(w_gnt_nxt);
            r_gnt_valid <= |w_gnt_nxt;
            r_timeout   <= w_timeout_nxt;
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.gnt_id    = r_gnt_id;
    assign bus.gnt_valid = r_gnt_valid;
    assign bus.timeout   = r_timeout;

endmodule

// File: tb/tb_rr_arb8.sv
// Testbench for rr_arb8 (MAX_HOLD = 4): directed vector table, hand-written
// corner sequences, then randomized traffic against a behavioural model.
module tb_rr_arb8;

    localparam int MH = 4;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    rr_arb8_if bus_if ();

    rr_arb8 #(.MAX_HOLD(MH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic       done;
        logic [7:0] gnt;
        logic [2:0] id;
        logic       valid;
        logic       to;
    } vec_t;

    vec_t vq[$];

    // Behavioural model: who owns the resource, for how many cycles so far.
    int   m_busy;
    int   m_owner;
    int   m_ptr;
    int   m_held;
    logic m_to;

    task automatic add(input logic r, input logic [7:0] q, input logic d,
                       input logic [7:0] g, input logic [2:0] id,
                       input logic v, input logic t);
        vec_t e;
        e.rst = r; e.req = q; e.done = d;
        e.gnt = g; e.id = id; e.valid = v; e.to = t;
        vq.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic [7:0] q, input logic d);
        bit a, b, c;
        if (r) begin
            m_busy = 0; m_owner = 0; m_ptr = 0; m_held = 0; m_to = 1'b0;
        end else if (m_busy == 0) begin
            m_to = 1'b0;
            for (int k = 0; k < 8; k++) begin
                if (m_busy == 0 && q[(m_ptr + k) % 8]) begin
                    m_busy  = 1;
                    m_owner = (m_ptr + k) % 8;
                    m_held  = 1;
                end
            end
        end else begin
            a = d;
            b = !q[m_owner];
            c = (m_held == MH);
            if (a || b || c) begin
                m_busy = 0;
                m_ptr  = (m_owner + 1) % 8;
                m_to   = c && !a && !b;
            end else begin
                m_held++;
                m_to = 1'b0;
            end
        end
    endtask

    // Drive inputs, advance one edge, update the model, settle before checking.
    task automatic apply(input logic r, input logic [7:0] q, input logic d);
        rst         = r;
        bus_if.req  = q;
        bus_if.done = d;
        @(posedge clk);
        #1;
        model_step(r, q, d);
    endtask

    task automatic chk_out(input string tag, input logic [7:0] g, input logic [2:0] id,
                           input logic v, input logic t);
        chk({tag, " gnt"},     32'(bus_if.gnt),       32'(g));
        chk({tag, " gnt_id"},  32'(bus_if.gnt_id),    32'(id));
        chk({tag, " valid"},   32'(bus_if.gnt_valid), 32'(v));
        chk({tag, " timeout"}, 32'(bus_if.timeout),   32'(t));
    endtask

    task automatic chk_model(input string tag);
        logic [7:0] g;
        g = (m_busy != 0) ? (8'd1 << m_owner) : 8'h00;
        chk_out(tag, g, (m_busy != 0) ? 3'(m_owner) : 3'd0, m_busy != 0, m_to);
    endtask

    initial begin
        logic [7:0] rq;
        logic       dn;
        logic       rs;
        total = 0;
        bad   = 0;
        rst = 1'b1; bus_if.req = 8'h00; bus_if.done = 1'b0;
        m_busy = 0; m_owner = 0; m_ptr = 0; m_held = 0; m_to = 1'b0;

        // Reset with all requests, then first grants.
        add(1, 8'hFF, 0, 8'h00, 0, 0, 0);
        add(1, 8'hFF, 0, 8'h00, 0, 0, 0);
        add(0, 8'hFF, 0, 8'h01, 0, 1, 0);
        add(0, 8'hFF, 1, 8'h00, 0, 0, 0);
        add(0, 8'hFF, 0, 8'h02, 1, 1, 0);
        add(0, 8'hFF, 1, 8'h00, 0, 0, 0);
        // Sparse fairness 2,7,2,7 then only 7.
        add(0, 8'h84, 0, 8'h04, 2, 1, 0);
        add(0, 8'h84, 1, 8'h00, 0, 0, 0);
        add(0, 8'h84, 0, 8'h80, 7, 1, 0);
        add(0, 8'h84, 1, 8'h00, 0, 0, 0);
        add(0, 8'h84, 0, 8'h04, 2, 1, 0);
        add(0, 8'h84, 1, 8'h00, 0, 0, 0);
        add(0, 8'h84, 0, 8'h80, 7, 1, 0);
        add(0, 8'h84, 1, 8'h00, 0, 0, 0);
        add(0, 8'h80, 0, 8'h80, 7, 1, 0);
        add(0, 8'h80, 1, 8'h00, 0, 0, 0);
        add(0, 8'h80, 0, 8'h80, 7, 1, 0);
        add(0, 8'h80, 1, 8'h00, 0, 0, 0);
        // Timeout: four grant cycles, timeout pulse, re-grant.
        add(0, 8'h10, 0, 8'h10, 4, 1, 0);
        add(0, 8'h10, 0, 8'h10, 4, 1, 0);
        add(0, 8'h10, 0, 8'h10, 4, 1, 0);
        add(0, 8'h10, 0, 8'h10, 4, 1, 0);
        add(0, 8'h10, 0, 8'h00, 0, 0, 1);
        add(0, 8'h10, 0, 8'h10, 4, 1, 0);
        // done in the 4th grant cycle: release without timeout.
        add(0, 8'h10, 0, 8'h10, 4, 1, 0);
        add(0, 8'h10, 0, 8'h10, 4, 1, 0);
        add(0, 8'h10, 0, 8'h10, 4, 1, 0);
        add(0, 8'h10, 1, 8'h00, 0, 0, 0);
        // Owner request drops in the timeout cycle: release without timeout.
        add(0, 8'h10, 0, 8'h10, 4, 1, 0);
        add(0, 8'h10, 0, 8'h10, 4, 1, 0);
        add(0, 8'h10, 0, 8'h10, 4, 1, 0);
        add(0, 8'h10, 0, 8'h10, 4, 1, 0);
        add(0, 8'h00, 0, 8'h00, 0, 0, 0);

        foreach (vq[i]) begin
            apply(vq[i].rst, vq[i].req, vq[i].done);
            chk_out($sformatf("vec%0d", i), vq[i].gnt, vq[i].id, vq[i].valid, vq[i].to);
        end

        // Full rotation with done in each first grant cycle.
        apply(1, 8'hFF, 0);
        for (int k = 0; k < 9; k++) begin
            apply(0, 8'hFF, 0);
            chk_out($sformatf("rot%0d", k), 8'd1 << (k % 8), 3'(k % 8), 1'b1, 1'b0);
            apply(0, 8'hFF, 1);
            chk_out($sformatf("rot%0d idle", k), 8'h00, 3'd0, 1'b0, 1'b0);
        end

        // Mid-grant reset: owner 5, reset, next grant goes to 0.
        apply(1, 8'h00, 0);
        apply(0, 8'h20, 0);
        chk_out("mid own5", 8'h20, 3'd5, 1'b1, 1'b0);
        apply(1, 8'h20, 0);
        chk_out("mid rst", 8'h00, 3'd0, 1'b0, 1'b0);
        apply(0, 8'hFF, 0);
        chk_out("mid regrant", 8'h01, 3'd0, 1'b1, 1'b0);

        // Owner 3 drops its request; pointer moves to 4.
        apply(0, 8'hFF, 1);
        apply(0, 8'h08, 0);
        chk_out("drop own3", 8'h08, 3'd3, 1'b1, 1'b0);
        apply(0, 8'h00, 0);
        chk_out("drop rel", 8'h00, 3'd0, 1'b0, 1'b0);
        apply(0, 8'h19, 0);
        chk_out("drop ptr4", 8'h10, 3'd4, 1'b1, 1'b0);

        // Randomized traffic against the model.
        apply(1, 8'h00, 0);
        rq = 8'hFF;
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(3) == 0) rq = 8'($urandom);
            dn = ($urandom_range(5) == 0);
            rs = ($urandom_range(63) == 0);
            apply(rs, rq, dn);
            chk_model($sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
